// File: rtl/hack_pkg.sv
// Hack CPU shared definitions: widths, instruction field bit positions and
// the 7-bit {a,c[5:0]} comp encodings used when building C-instructions.
// Helper c_instr() assembles a C-instruction word from comp/dest/jump fields.
package hack_pkg;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 15;

  localparam int BIT_C  = 15;  // 1 = C-instruction
  localparam int BIT_A  = 12;  // y operand: 1 = in_m, 0 = A
  localparam int BIT_ZX = 11;
  localparam int BIT_NX = 10;
  localparam int BIT_ZY = 9;
  localparam int BIT_NY = 8;
  localparam int BIT_F  = 7;
  localparam int BIT_NO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  localparam logic [6:0] COMP_ZERO     = 7'b0101010;
  localparam logic [6:0] COMP_D        = 7'b0001100;
  localparam logic [6:0] COMP_A        = 7'b0110000;
  localparam logic [6:0] COMP_A_PLUS_1 = 7'b0110111;
  localparam logic [6:0] COMP_D_PLUS_A = 7'b0000010;
  localparam logic [6:0] COMP_D_PLUS_M = 7'b1000010;

  function automatic logic [WIDTH-1:0] c_instr(input logic [6:0] comp,
                                               input logic [2:0] dest,
                                               input logic [2:0] jmp);
    return {3'b111, comp, dest, jmp};
  endfunction
endpackage

// File: rtl/alu.sv
// Hack ALU (combinational).
// Ports: x,y operands; zx/nx/zy/ny/f/no control; out result; zr (out==0);
// ng (out negative).
module alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] x1, x2, y1, y2, r;

  assign x1  = zx ? '0 : x;
  assign x2  = nx ? ~x1 : x1;
  assign y1  = zy ? '0 : y;
  assign y2  = ny ? ~y1 : y1;
  assign r   = f ? (x2 + y2) : (x2 & y2);
  assign out = no ? ~r : r;
  assign zr  = (out == '0);
  assign ng  = out[WIDTH-1];
endmodule

// File: rtl/hack_jump.sv
// Jump condition evaluation.
// Ports: ng_i/zr_i ALU flags; jmp_i {lt,eq,gt}; take_o = branch taken.
module hack_jump (
  input  logic       ng_i,
  input  logic       zr_i,
  input  logic [2:0] jmp_i,
  output logic       take_o
);
  assign take_o = (jmp_i[2] & ng_i) | (jmp_i[1] & zr_i) | (jmp_i[0] & ~ng_i & ~zr_i);
endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: decodes the instruction word, drives the ALU, holds A/D/PC.
// Ports: clk, reset (sync, high), instruction (ROM[pc]), in_m (RAM read),
// stall (freeze state); out_m (ALU result, comb), write_m (RAM strobe),
// address_m (A low bits), pc; illegal (only with HACK_ILLEGAL_EN defined).
// Build option: HACK_ILLEGAL_EN -- C-instructions whose bits[14:13]!=2'b11
// flag illegal and execute as NOP.
module hack_cpu
  import hack_pkg::*;
#(
  parameter int WIDTH    = hack_pkg::WIDTH,
  parameter int ADDR_W   = hack_pkg::ADDR_W,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instruction,
  input  logic [WIDTH-1:0]  in_m,
  input  logic              stall,
  output logic [WIDTH-1:0]  out_m,
  output logic              write_m,
  output logic [ADDR_W-1:0] address_m,
`ifdef HACK_ILLEGAL_EN
  output logic              illegal,
`endif
  output logic [ADDR_W-1:0] pc
);
  logic [WIDTH-1:0]  a_q, a_d, d_q, d_d, alu_out;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              is_c, bad, exec_c, zr, ng, take;

  assign is_c = instruction[BIT_C];
`ifdef HACK_ILLEGAL_EN
  assign bad     = is_c & (instruction[14:13] != 2'b11);
  assign illegal = bad & ~reset;
`else
  assign bad     = 1'b0;
`endif
  assign exec_c = is_c & ~bad;

  // x is always D; a-bit picks memory or A for y
  alu #(.WIDTH(WIDTH)) u_alu (
    .x  (d_q),
    .y  (instruction[BIT_A] ? in_m : a_q),
    .zx (instruction[BIT_ZX]),
    .nx (instruction[BIT_NX]),
    .zy (instruction[BIT_ZY]),
    .ny (instruction[BIT_NY]),
    .f  (instruction[BIT_F]),
    .no (instruction[BIT_NO]),
    .out(alu_out),
    .zr (zr),
    .ng (ng)
  );

  hack_jump u_jump (
    .ng_i  (ng),
    .zr_i  (zr),
    .jmp_i (instruction[JMP_LT:JMP_GT]),
    .take_o(take)
  );

  // Next state is computed from old register values, so a jump that also
  // writes A targets the old A, and D-dest uses old D as the operand.
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + ADDR_W'(1);
    if (!is_c) begin
      a_d = instruction;
    end else if (exec_c) begin
      if (instruction[DEST_A]) a_d = alu_out;
      if (instruction[DEST_D]) d_d = alu_out;
      if (take) pc_d = a_q[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= ADDR_W'(RESET_PC);
    end else if (!stall) begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  assign out_m     = alu_out;
  assign write_m   = exec_c & instruction[DEST_M] & ~stall & ~reset;
  assign address_m = a_q[ADDR_W-1:0];
  assign pc        = pc_q;
endmodule
